// File: rtl/sipo_collect_if.sv
// Bundle of the serial-in and parallel-out handshake signals of sipo_collect.
// The producer/consumer side uses master; the collector uses slave.
interface sipo_collect_if #(
  parameter int N = 16
);
  localparam int CW = $clog2(N);

  logic          in_bit;
  logic          in_valid;
  logic          in_ready;
  logic          clear;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  out;
  logic          out_valid;
  logic          out_ready;

  modport master (
    output in_bit, in_valid, clear, out_ready,
    input  in_ready, bit_cnt, out, out_valid
  );

  modport slave (
    input  in_bit, in_valid, clear, out_ready,
    output in_ready, bit_cnt, out, out_valid
  );
endinterface

// File: rtl/sipo_collect.sv
// Serial-in, parallel-out word collector: gathers N handshaked bits into a word
// and hands it to a one-entry output buffer with its own handshake.
module sipo_collect #(
  parameter int N     = 16,
  parameter bit RIGHT = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  sipo_collect_if.slave  bus
);
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // Handshakes: a bit transfers on a clk edge where in_valid & in_ready are both
  // high; a word transfers where out_valid & out_ready are both high. Neither
  // ready depends on its own valid.
  logic [N-1:0]  sr;
  logic [N-1:0]  obuf;
  logic [N-1:0]  nxt;
  logic [CW-1:0] cnt;
  logic          ov;
  logic          last;
  logic          acc;

  assign last = (cnt == LAST);

  // Only the word-completing bit waits for room; earlier bits keep collecting.
  assign bus.in_ready = !(last && ov && !bus.out_ready);
  assign acc          = bus.in_valid && bus.in_ready;

  generate
    if (RIGHT) begin : g_lsb_first
      assign nxt = {bus.in_bit, sr[N-1:1]};
    end else begin : g_msb_first
      assign nxt = {sr[N-2:0], bus.in_bit};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sr   <= '0;
      cnt  <= '0;
      obuf <= '0;
      ov   <= 1'b0;
    end else if (bus.clear) begin
      sr   <= '0;
      cnt  <= '0;
      obuf <= '0;
      ov   <= 1'b0;
    end else if (acc && last) begin
      // A completing word overrides any consume in the same cycle, so ov stays set.
      obuf <= nxt;
      ov   <= 1'b1;
      sr   <= '0;
      cnt  <= '0;
    end else begin
      if (acc) begin
        sr  <= nxt;
        cnt <= cnt + 1'b1;
      end
      if (ov && bus.out_ready) begin
        ov <= 1'b0;
      end
    end
  end

  assign bus.bit_cnt   = cnt;
  assign bus.out       = obuf;
  assign bus.out_valid = ov;
endmodule

// File: tb/tb_sipo_collect.sv
// Bench for sipo_collect: one LSB-first and one MSB-first instance, directed
// streams, and a per-instance expected-word queue drained by output monitors.
module tb_sipo_collect;
  localparam int N = 16;

  logic clk;
  logic reset_n;

  sipo_collect_if #(.N(N)) r_if ();
  sipo_collect_if #(.N(N)) l_if ();

  sipo_collect #(.N(N), .RIGHT(1'b1)) dut_r (.clk(clk), .reset_n(reset_n), .bus(r_if.slave));
  sipo_collect #(.N(N), .RIGHT(1'b0)) dut_l (.clk(clk), .reset_n(reset_n), .bus(l_if.slave));

  int checks = 0;
  int errors = 0;
  logic [N-1:0] exp_r_q[$];
  logic [N-1:0] exp_l_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit sel, input logic b, input logic v);
    if (sel) begin
      l_if.in_bit = b; l_if.in_valid = v;
    end else begin
      r_if.in_bit = b; r_if.in_valid = v;
    end
  endtask

  function automatic logic rdy(input bit sel);
    return sel ? l_if.in_ready : r_if.in_ready;
  endfunction

  function automatic logic [31:0] cnt_of(input bit sel);
    return sel ? 32'(l_if.bit_cnt) : 32'(r_if.bit_cnt);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one bit and hold it until accepted (bounded wait).
  task automatic send_bit(input bit sel, input logic b, input bit nostall);
    int guard;
    drive(sel, b, 1'b1);
    @(negedge clk);
    if (nostall) check("in_ready_nostall", 32'(rdy(sel)), 32'd1);
    guard = 0;
    while (!rdy(sel) && guard < 64) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 64) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1 at %0t", $time);
    end
    tick();
  endtask

  // LSB-first for the RIGHT instance (sel=0), MSB-first for the other.
  task automatic send_bits(input bit sel, input logic [N-1:0] word, input int nbits, input bit nostall);
    for (int i = 0; i < nbits; i++) begin
      send_bit(sel, sel ? word[N-1-i] : word[i], nostall);
      check("bit_cnt", cnt_of(sel), 32'((i + 1) % N));
    end
  endtask

  task automatic idle(input bit sel);
    drive(sel, 1'b0, 1'b0);
  endtask

  // ---------------- monitors / scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && r_if.out_valid && r_if.out_ready) begin
      if (exp_r_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL r_unexpected_word: got 0x%0h expected no word at %0t", r_if.out, $time);
      end else begin
        check("r_word", 32'(r_if.out), 32'(exp_r_q.pop_front()));
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n && l_if.out_valid && l_if.out_ready) begin
      if (exp_l_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL l_unexpected_word: got 0x%0h expected no word at %0t", l_if.out, $time);
      end else begin
        check("l_word", 32'(l_if.out), 32'(exp_l_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    r_if.in_bit = 1'b0; r_if.in_valid = 1'b0; r_if.clear = 1'b0; r_if.out_ready = 1'b1;
    l_if.in_bit = 1'b0; l_if.in_valid = 1'b0; l_if.clear = 1'b0; l_if.out_ready = 1'b1;
    tick(); tick();
    reset_n = 1'b1;
    tick();

    check("rst_r_out", 32'(r_if.out), 32'd0);
    check("rst_r_valid", 32'(r_if.out_valid), 32'd0);
    check("rst_r_cnt", cnt_of(0), 32'd0);
    check("rst_r_ready", 32'(r_if.in_ready), 32'd1);
    check("rst_l_out", 32'(l_if.out), 32'd0);
    check("rst_l_ready", 32'(l_if.in_ready), 32'd1);

    // 1: LSB first, continuous, out_valid for exactly one cycle
    exp_r_q.push_back(16'hA5C3);
    send_bits(0, 16'hA5C3, N, 1);
    idle(0);
    check("t1_valid", 32'(r_if.out_valid), 32'd1);
    check("t1_out", 32'(r_if.out), 32'hA5C3);
    tick();
    check("t1_valid_drop", 32'(r_if.out_valid), 32'd0);

    // 2: MSB first, then two words back-to-back with no stall
    exp_l_q.push_back(16'hA5C3);
    send_bits(1, 16'hA5C3, N, 1);
    idle(1);
    check("t2_out", 32'(l_if.out), 32'hA5C3);
    tick();
    exp_l_q.push_back(16'h1234);
    exp_l_q.push_back(16'hFEDC);
    send_bits(1, 16'h1234, N, 1);
    check("t2_mid_out", 32'(l_if.out), 32'h1234);
    send_bits(1, 16'hFEDC, N, 1);
    idle(1);
    check("t2_last_out", 32'(l_if.out), 32'hFEDC);
    tick();

    // 3: backpressure on the word-completing bit only
    r_if.out_ready = 1'b0;
    exp_r_q.push_back(16'h00FF);
    send_bits(0, 16'h00FF, N, 1);
    send_bits(0, 16'h3C96, N - 1, 1);
    drive(0, 1'b0, 1'b1);  // bit 15 of 0x3C96
    @(negedge clk);
    check("t3_stall_ready", 32'(r_if.in_ready), 32'd0);
    check("t3_stall_cnt", cnt_of(0), 32'd15);
    check("t3_hold_out", 32'(r_if.out), 32'h00FF);
    tick();
    check("t3_still_stalled", 32'(r_if.in_ready), 32'd0);
    check("t3_hold_valid", 32'(r_if.out_valid), 32'd1);
    exp_r_q.push_back(16'h3C96);
    r_if.out_ready = 1'b1;
    @(negedge clk);
    check("t3_release_ready", 32'(r_if.in_ready), 32'd1);
    tick();
    r_if.out_ready = 1'b0;
    idle(0);
    check("t3_new_out", 32'(r_if.out), 32'h3C96);
    check("t3_valid_kept", 32'(r_if.out_valid), 32'd1);
    check("t3_cnt_wrap", cnt_of(0), 32'd0);
    r_if.out_ready = 1'b1;
    tick();
    check("t3_drained", 32'(r_if.out_valid), 32'd0);

    // 4: gaps between every bit; invalid bits are inverted and must be ignored
    exp_r_q.push_back(16'h8001);
    for (int i = 0; i < N; i++) begin
      send_bit(0, 1'(16'h8001 >> i), 0);
      drive(0, ~r_if.in_bit, 1'b0);
      tick();
      check("t4_gap_cnt", cnt_of(0), 32'((i + 1) % N));
    end
    check("t4_out", 32'(r_if.out), 32'h8001);

    // 5: clear with a buffered word and a partial word
    r_if.out_ready = 1'b0;
    send_bits(0, 16'h1111, N, 1);
    send_bits(0, 16'h0000, 7, 1);
    check("t5_pre_valid", 32'(r_if.out_valid), 32'd1);
    check("t5_pre_out", 32'(r_if.out), 32'h1111);
    drive(0, 1'b1, 1'b1);
    r_if.clear = 1'b1;
    @(negedge clk);
    check("t5_ready_ungated", 32'(r_if.in_ready), 32'd1);
    tick();
    r_if.clear = 1'b0;
    idle(0);
    check("t5_cnt", cnt_of(0), 32'd0);
    check("t5_valid", 32'(r_if.out_valid), 32'd0);
    check("t5_out", 32'(r_if.out), 32'd0);
    r_if.out_ready = 1'b1;
    exp_r_q.push_back(16'h5555);
    send_bits(0, 16'h5555, N, 1);
    idle(0);
    check("t5_new_out", 32'(r_if.out), 32'h5555);
    tick();

    // 6: reset mid-word with a buffered word
    r_if.out_ready = 1'b0;
    send_bits(0, 16'h7777, N, 1);
    send_bits(0, 16'hFFFF, 9, 1);
    idle(0);
    check("t6_pre_cnt", cnt_of(0), 32'd9);
    check("t6_pre_valid", 32'(r_if.out_valid), 32'd1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("t6_out", 32'(r_if.out), 32'd0);
    check("t6_valid", 32'(r_if.out_valid), 32'd0);
    check("t6_cnt", cnt_of(0), 32'd0);
    check("t6_ready", 32'(r_if.in_ready), 32'd1);
    r_if.out_ready = 1'b1;
    exp_r_q.push_back(16'h0F0F);
    send_bits(0, 16'h0F0F, N, 1);
    idle(0);
    check("t6_new_out", 32'(r_if.out), 32'h0F0F);
    tick(); tick();

    check("r_queue_empty", 32'(exp_r_q.size()), 32'd0);
    check("l_queue_empty", 32'(exp_l_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
